ecc_scrub_ctrl: RTL and testbench



---
 rtl/ecc_scrub_ctrl.sv | 159 +++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
//   Scrub scheduler and ECC error accountant around the cache ECC scrubber.
//   - Emits a one-cycle scrub_trigger_o every max(interval_i, MinInterval)
//     cycles. The countdown stalls on cycles where the bank is busy with
//     cache traffic.
//   - Keeps saturating counters of corrected and uncorrectable error pulses.
//   - Raises a sticky interrupt when the macro ECC_SCRUB_CTRL_IRQ_EN is
//     defined. Without it, irq_o is tied low and the threshold and ack
//     inputs are ignored.
//   All outputs are registered; no input reaches an output combinationally.
module ecc_scrub_ctrl #(
   parameter int IntervalWidth = 16,
   parameter int CntWidth      = 16,
   parameter int MinInterval   = 3   // must be >= 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic [IntervalWidth-1:0] interval_i,
   input  logic                     intc_busy_i,
   output logic                     scrub_trigger_o,
   input  logic                     bit_corrected_i,
   input  logic                     uncorrectable_i,
   input  logic                     clear_i,
   input  logic [CntWidth-1:0]      corr_threshold_i,
   input  logic                     irq_ack_i,
   output logic [CntWidth-1:0]      corr_count_o,
   output logic [CntWidth-1:0]      uncorr_count_o,
   output logic                     irq_o
);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_WAIT     = 2'd1,
      ST_FIRE     = 2'd2
   } state_e;

   localparam logic [IntervalWidth-1:0] MinIntervalW = IntervalWidth'(MinInterval);
   localparam logic [CntWidth-1:0]      CntMax       = {CntWidth{1'b1}};

   state_e                   state_q;
   logic [IntervalWidth-1:0] cnt_q;
   logic                     trigger_q;

   logic [IntervalWidth-1:0] eff_interval;
   logic [IntervalWidth-1:0] load_val;

   // The Wait state spends L-1 cycles counting from L-2 down to 0, and
   // Fire adds one more cycle, which gives a trigger period of L.
   assign eff_interval = (interval_i < MinIntervalW) ? MinIntervalW : interval_i;
   assign load_val     = eff_interval - IntervalWidth'(2);

   // Scheduler FSM. The trigger is registered and is high exactly in Fire.
   // Dropping enable_i wins over every transition, including a pending Fire.
   // NOTE: All state is updated with non-blocking assignments. This lets
   // every branch read the pre-edge values of state_q and cnt_q.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_DISABLED;
         cnt_q     <= '0;
         trigger_q <= 1'b0;
      end else if (!enable_i) begin
         state_q   <= ST_DISABLED;
         trigger_q <= 1'b0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               state_q   <= ST_WAIT;
               cnt_q     <= load_val;
               trigger_q <= 1'b0;
            end
            ST_WAIT: begin
               trigger_q <= 1'b0;
               if (!intc_busy_i) begin
                  if (cnt_q == '0) begin
                     state_q   <= ST_FIRE;
                     trigger_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - IntervalWidth'(1);
                  end
               end
            end
            ST_FIRE: begin
               state_q   <= ST_WAIT;
               cnt_q     <= load_val;
               trigger_q <= 1'b0;
            end
            default: begin
               state_q   <= ST_DISABLED;
               trigger_q <= 1'b0;
            end
         endcase
      end
   end

   assign scrub_trigger_o = trigger_q;

   // Error event counters. They saturate at all-ones, and clear_i wins over
   // an event in the same cycle.
   logic [CntWidth-1:0] corr_q;
   logic [CntWidth-1:0] uncorr_q;
   logic                corr_inc;
   logic                uncorr_inc;

   assign corr_inc   = bit_corrected_i && (corr_q != CntMax);
   assign uncorr_inc = uncorrectable_i && (uncorr_q != CntMax);

   // Counter update with saturation and synchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else if (clear_i) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else begin
         if (corr_inc) begin
            corr_q <= corr_q + CntWidth'(1);
         end
         if (uncorr_inc) begin
            uncorr_q <= uncorr_q + CntWidth'(1);
         end
      end
   end

   assign corr_count_o   = corr_q;
   assign uncorr_count_o = uncorr_q;

`ifdef ECC_SCRUB_CTRL_IRQ_EN
   // The threshold source fires only when the count actually moves onto the
   // threshold value. A saturated or cleared count does not fire it.
   logic irq_q;
   logic thr_hit;
   logic irq_set;

   assign thr_hit = corr_inc && !clear_i && (corr_threshold_i != '0) &&
                    ((corr_q + CntWidth'(1)) == corr_threshold_i);
   assign irq_set = uncorrectable_i || thr_hit;

   // Sticky interrupt. A set in the same cycle as an ack wins over the ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
      end else if (irq_set) begin
         irq_q <= 1'b1;
      end else if (irq_ack_i) begin
         irq_q <= 1'b0;
      end
   end

   assign irq_o = irq_q;
`else
   // Interrupt logic is compiled out, so its inputs are deliberately unused.
   logic unused_irq_inputs;
   assign unused_irq_inputs = ^{corr_threshold_i, irq_ack_i};
   assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl. The bench uses directed scenarios
// from the test plan plus a randomized run. Outputs are compared against a
// reference model that tracks progress toward the next trigger as a count
// of non-busy waiting cycles.
module tb_ecc_scrub_ctrl;

   localparam int IW = 16;
   localparam int CW = 4;
   localparam int MinIv = 3;
`ifdef ECC_SCRUB_CTRL_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [IW-1:0] interval = '0;
   logic          busy = 1'b0;
   logic          trig;
   logic          bit_corr = 1'b0;
   logic          unc = 1'b0;
   logic          clear = 1'b0;
   logic [CW-1:0] thr = '0;
   logic          ack = 1'b0;
   logic [CW-1:0] corr_cnt;
   logic [CW-1:0] unc_cnt;
   logic          irq;

   int checks = 0;
   int errors = 0;

   ecc_scrub_ctrl #(
      .IntervalWidth(IW),
      .CntWidth     (CW),
      .MinInterval  (MinIv)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .enable_i        (enable),
      .interval_i      (interval),
      .intc_busy_i     (busy),
      .scrub_trigger_o (trig),
      .bit_corrected_i (bit_corr),
      .uncorrectable_i (unc),
      .clear_i         (clear),
      .corr_threshold_i(thr),
      .irq_ack_i       (ack),
      .corr_count_o    (corr_cnt),
      .uncorr_count_o  (unc_cnt),
      .irq_o           (irq)
   );

   always #5 clk = ~clk;

   // Reference model state.
   bit m_active;   // scheduling enabled
   bit m_fire;     // the current cycle is a trigger cycle
   int m_len;      // effective interval latched at the last reference edge
   int m_prog;     // non-busy waiting cycles since the last reference edge
   int m_corr;
   int m_unc;
   bit m_irq;

   task automatic model_reset();
      m_active = 0; m_fire = 0; m_len = 0; m_prog = 0;
      m_corr = 0; m_unc = 0; m_irq = 0;
   endtask

   // Advance one clock. The model uses the inputs sampled at the edge, and
   // the task returns 1 time unit after the edge.
   task automatic tick();
      int old_corr;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (!enable) begin
            m_active = 0;
            m_fire   = 0;
         end else if (!m_active || m_fire) begin
            // The enable edge or the end of a trigger starts a new interval.
            m_active = 1;
            m_fire   = 0;
            m_len    = (int'(interval) < MinIv) ? MinIv : int'(interval);
            m_prog   = 0;
         end else begin
            if (!busy) m_prog++;
            if (m_prog == m_len - 1) m_fire = 1;
         end
         old_corr = m_corr;
         if (clear) begin
            m_corr = 0;
            m_unc  = 0;
         end else begin
            if (bit_corr) m_corr = (m_corr < (1 << CW) - 1) ? m_corr + 1 : m_corr;
            if (unc)      m_unc  = (m_unc  < (1 << CW) - 1) ? m_unc + 1  : m_unc;
         end
         if (IrqEn) begin
            if (unc || (thr != 0 && m_corr != old_corr && m_corr == int'(thr)))
               m_irq = 1;
            else if (ack)
               m_irq = 0;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      enable = 0; busy = 0; bit_corr = 0; unc = 0; clear = 0; ack = 0; thr = '0;
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1;
      #2;
      checks++;
      if (trig !== 1'b0 || corr_cnt !== '0 || unc_cnt !== '0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: trig=%b corr=%0d unc=%0d irq=%b, expected all 0",
                  trig, corr_cnt, unc_cnt, irq);
      end
      enable = 1; bit_corr = 1; unc = 1;  // all ignored while reset is held
      tick(); tick();
      checks++;
      if (trig !== 1'b0 || corr_cnt !== '0 || unc_cnt !== '0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: trig=%b corr=%0d unc=%0d irq=%b, expected all 0",
                  trig, corr_cnt, unc_cnt, irq);
      end
      idle_inputs();
      rst = 0;
      tick();
   endtask

   task automatic test_interval();
      interval = 16'd5;
      enable   = 1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         checks++;
         if (trig !== ((c % 5) == 0)) begin
            errors++;
            $display("FAIL interval5 cycle %0d: trig=%b expected %b", c, trig, (c % 5) == 0);
         end
      end
      enable = 0;
      tick(); tick();
   endtask

   task automatic test_clamp_abort();
      interval = 16'd1;
      enable   = 1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         checks++;
         if (trig !== ((c % 3) == 0)) begin
            errors++;
            $display("FAIL clamp cycle %0d: trig=%b expected %b", c, trig, (c % 3) == 0);
         end
      end
      // Cycle 8 is the cycle before the next trigger. Dropping enable here
      // must cancel that trigger.
      enable = 0;
      for (int c = 9; c <= 12; c++) begin
         tick();
         checks++;
         if (trig !== 1'b0) begin
            errors++;
            $display("FAIL abort cycle %0d: trig=%b expected 0", c, trig);
         end
      end
      enable = 1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++;
         if (trig !== (c == 3)) begin
            errors++;
            $display("FAIL reenable cycle %0d: trig=%b expected %b", c, trig, c == 3);
         end
      end
      enable = 0;
      tick(); tick();
   endtask

   task automatic test_busy_stall();
      interval = 16'd8;
      enable   = 1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         checks++;
         if (trig !== (c == 12)) begin
            errors++;
            $display("FAIL busy_stall cycle %0d: trig=%b expected %b", c, trig, c == 12);
         end
         busy = (c >= 3 && c <= 6);
      end
      busy = 0; enable = 0;
      tick(); tick();
   endtask

   task automatic test_saturation_clear();
      clear = 1;
      tick();
      clear    = 0;
      bit_corr = 1;
      for (int n = 1; n <= 17; n++) begin
         tick();
         checks++;
         if (int'(corr_cnt) !== ((n < 15) ? n : 15)) begin
            errors++;
            $display("FAIL corr_sat pulse %0d: count=%0d expected %0d", n, corr_cnt, (n < 15) ? n : 15);
         end
      end
      bit_corr = 0;
      unc      = 1;
      tick();
      tick();
      unc   = 1;
      clear = 1;
      tick();
      checks++;
      if (corr_cnt !== '0 || unc_cnt !== '0) begin
         errors++;
         $display("FAIL clear_wins: corr=%0d unc=%0d expected 0 0", corr_cnt, unc_cnt);
      end
      unc = 0; clear = 0;
      tick();
   endtask

   task automatic test_irq();
      ack = 1;
      tick();
      ack   = 0;
      clear = 1;
      tick();
      clear = 0;
      thr   = 4'd3;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_after_ack: irq=%b expected 0", irq);
      end
      bit_corr = 1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         checks++;
         if (irq !== (IrqEn && n == 3)) begin
            errors++;
            $display("FAIL irq_threshold pulse %0d: irq=%b expected %b", n, irq, IrqEn && n == 3);
         end
      end
      bit_corr = 0;
      ack = 1; unc = 1;
      tick();
      checks++;
      if (irq !== IrqEn) begin
         errors++;
         $display("FAIL irq_set_beats_ack: irq=%b expected %b", irq, IrqEn);
      end
      unc = 0;
      tick();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_ack_alone: irq=%b expected 0", irq);
      end
      ack = 0; thr = '0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         enable   = ($urandom_range(0, 99) < 92);
         busy     = ($urandom_range(0, 99) < 30);
         interval = IW'($urandom_range(0, 12));
         bit_corr = ($urandom_range(0, 99) < 35);
         unc      = ($urandom_range(0, 99) < 5);
         clear    = ($urandom_range(0, 99) < 4);
         ack      = ($urandom_range(0, 99) < 10);
         thr      = CW'($urandom_range(0, 15));
         tick();
         checks++;
         if (trig !== m_fire) begin
            errors++;
            $display("FAIL rand_trig iter %0d: trig=%b expected %b", i, trig, m_fire);
         end
         checks++;
         if (int'(corr_cnt) !== m_corr || int'(unc_cnt) !== m_unc) begin
            errors++;
            $display("FAIL rand_counts iter %0d: corr=%0d unc=%0d expected %0d %0d",
                     i, corr_cnt, unc_cnt, m_corr, m_unc);
         end
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL rand_irq iter %0d: irq=%b expected %b", i, irq, m_irq);
         end
      end
      idle_inputs();
      tick(); tick();
   endtask

   task automatic test_reset_mid_fire();
      bit seen;
      bit_corr = 1; unc = 1;
      tick();
      bit_corr = 0; unc = 0;
      interval = 16'd4;
      enable   = 1;
      seen     = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         seen = (trig === 1'b1);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_fire_setup: no trigger seen within 20 cycles");
      end
      rst = 1;
      #1;
      checks++;
      if (trig !== 1'b0 || corr_cnt !== '0 || unc_cnt !== '0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fire: trig=%b corr=%0d unc=%0d irq=%b, expected all 0",
                  trig, corr_cnt, unc_cnt, irq);
      end
      model_reset();
      #1;
      rst = 0;
      // With enable still high, the first trigger must again come 4 cycles
      // after the first edge. This shows the FSM restarted from Disabled.
      for (int c = 1; c <= 9; c++) begin
         tick();
         checks++;
         if (trig !== ((c % 4) == 0)) begin
            errors++;
            $display("FAIL post_reset cycle %0d: trig=%b expected %b", c, trig, (c % 4) == 0);
         end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_interval();
      test_clamp_abort();
      test_busy_stall();
      test_saturation_clear();
      test_irq();
      test_random();
      test_reset_mid_fire();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
